// File: rtl/operand_fetch_stage.sv
// Operand fetch: register file read, immediate expansion, one-entry output register.
// Define OF_WB_BYPASS_EN to forward a same-cycle write-back onto the read ports.
module operand_fetch_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 16,
    parameter int RA_REG   = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic            in_is_ret,
    input  logic            in_is_st,
    input  logic            in_flush,
    input  logic            wb_en,
    input  logic [3:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_sdata,
    output logic [3:0]      out_rd,
    output logic [31:0]     out_inst
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef logic [AW-1:0] ridx_t;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] sdata;
        logic [3:0]      rd;
        logic [31:0]     inst;
    } of_ex_t;

    localparam logic [3:0] RA_IDX = 4'(RA_REG);

    logic [XLEN-1:0] regs [NUM_REGS];

    logic [3:0]      f_rd;
    logic [3:0]      f_rs1;
    logic [3:0]      f_rs2;
    logic            f_imm_sel;
    logic [1:0]      f_mod;
    logic [15:0]     f_imm;

    ridx_t           a_idx;
    ridx_t           b_idx;
    ridx_t           c_idx;
    ridx_t           wb_idx;

    logic [XLEN-1:0] a_raw;
    logic [XLEN-1:0] b_raw;
    logic [XLEN-1:0] c_raw;
    logic [XLEN-1:0] a_data;
    logic [XLEN-1:0] b_data;
    logic [XLEN-1:0] c_data;

    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_z;
    logic [XLEN-1:0] imm_h;
    logic [XLEN-1:0] immx;

    logic            xfer;
    of_ex_t          nxt;
    of_ex_t          q;

    assign f_rd      = in_inst[25:22];
    assign f_rs1     = in_inst[21:18];
    assign f_rs2     = in_inst[17:14];
    assign f_imm_sel = in_inst[26];
    assign f_mod     = in_inst[17:16];
    assign f_imm     = in_inst[15:0];

    // Only the low AW index bits select a register.
    assign a_idx  = in_is_ret ? RA_IDX[AW-1:0] : f_rs1[AW-1:0];
    assign b_idx  = f_rs2[AW-1:0];
    assign c_idx  = f_rd[AW-1:0];
    assign wb_idx = wb_addr[AW-1:0];

    assign a_raw = regs[a_idx];
    assign b_raw = regs[b_idx];
    assign c_raw = regs[c_idx];

`ifdef OF_WB_BYPASS_EN
    assign a_data = (wb_en && wb_idx == a_idx) ? wb_data : a_raw;
    assign b_data = (wb_en && wb_idx == b_idx) ? wb_data : b_raw;
    assign c_data = (wb_en && wb_idx == c_idx) ? wb_data : c_raw;
`else
    assign a_data = a_raw;
    assign b_data = b_raw;
    assign c_data = c_raw;
`endif

    // Upper-half form naturally shifts out to zero when XLEN is 16.
    assign imm_s = XLEN'($signed(f_imm));
    assign imm_z = XLEN'(f_imm);
    assign imm_h = imm_z << 16;

    always_comb begin
        immx = imm_s;
        unique case (1'b1)
            (f_mod == 2'b01): immx = imm_z;
            (f_mod == 2'b10): immx = imm_h;
            default:          immx = imm_s;
        endcase
    end

    always_comb begin
        nxt       = '0;
        nxt.op1   = a_data;
        nxt.op2   = f_imm_sel ? immx : b_data;
        nxt.sdata = in_is_st ? c_data : '0;
        nxt.rd    = f_rd;
        nxt.inst  = in_inst;
    end

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready && !in_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_idx] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            out_valid <= 1'b0;
        end else if (in_flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            q         <= nxt;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_op1   = q.op1;
    assign out_op2   = q.op2;
    assign out_sdata = q.sdata;
    assign out_rd    = q.rd;
    assign out_inst  = q.inst;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed and randomized checks of operand_fetch_stage against a transaction-level model.
// Honours OF_WB_BYPASS_EN the same way the design does.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        in_is_ret;
    logic        in_is_st;
    logic        in_flush;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [31:0] out_sdata;
    logic [3:0]  out_rd;
    logic [31:0] out_inst;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [16];
    logic        m_valid;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [31:0] m_sd;
    logic [3:0]  m_rd;
    logic [31:0] m_inst;
    logic [31:0] snap_op1;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_is_ret(in_is_ret), .in_is_st(in_is_st),
        .in_flush(in_flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_sdata(out_sdata),
        .out_rd(out_rd), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        logic [31:0] w;
        w = '0;
        w[25:22] = 4'(rd);
        w[21:18] = 4'(rs1);
        w[17:14] = 4'(rs2);
        return w;
    endfunction

    function automatic logic [31:0] mki(input int rd, input int rs1, input int md, input int imm);
        logic [31:0] w;
        w = '0;
        w[26] = 1'b1;
        w[25:22] = 4'(rd);
        w[21:18] = 4'(rs1);
        w[17:16] = 2'(md);
        w[15:0] = 16'(imm);
        return w;
    endfunction

    // Architectural read as seen by the instruction in this cycle.
    function automatic logic [31:0] rf(input logic [3:0] idx);
`ifdef OF_WB_BYPASS_EN
        if (wb_en && wb_addr == idx) return wb_data;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] expand(input logic [1:0] md, input logic [15:0] imm);
        int unsigned u;
        u = imm;
        case (md)
            2'd1:    return u;
            2'd2:    return u * 65536;
            default: return (imm >= 16'h8000) ? (u + 32'hFFFF0000) : u;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_valid = 0; m_op1 = 0; m_op2 = 0; m_sd = 0; m_rd = 0; m_inst = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m_valid});
        check({tag, ".op1"}, out_op1, m_op1);
        check({tag, ".op2"}, out_op2, m_op2);
        check({tag, ".sdata"}, out_sdata, m_sd);
        check({tag, ".rd"}, {28'b0, out_rd}, {28'b0, m_rd});
        check({tag, ".inst"}, out_inst, m_inst);
    endtask

    // One clock: check the ready output, advance the model, then compare the outputs.
    task automatic step(input string tag);
        logic rdy;
        #1;
        rdy = !m_valid || out_ready;
        check({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
        if (rst) begin
            model_reset();
        end else begin
            if (in_flush) begin
                m_valid = 0;
            end else if (in_valid && rdy) begin
                m_op1  = rf(in_is_ret ? 4'd15 : in_inst[21:18]);
                m_op2  = in_inst[26] ? expand(in_inst[17:16], in_inst[15:0])
                                     : rf(in_inst[17:14]);
                m_sd   = in_is_st ? rf(in_inst[25:22]) : 32'h0;
                m_rd   = in_inst[25:22];
                m_inst = in_inst;
                m_valid = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (wb_en) m_regs[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; in_inst = 0; in_is_ret = 0; in_is_st = 0;
        in_flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        wb_en = 1; wb_addr = 4'(a); wb_data = d;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        step("reset");
        rst = 0;
        check("reset.ready_after", {31'b0, in_ready}, 32'd1);

        wb(3, 32'h1234);
        step("wr_r3");
        idle();
        in_valid = 1; in_inst = mk(1, 3, 3);
        step("add_r3");
        check("add.op1", out_op1, 32'h0000_1234);
        check("add.op2", out_op2, 32'h0000_1234);
        check("add.valid", {31'b0, out_valid}, 32'd1);

        idle();
        wb(15, 32'h80);
        step("wr_r15");
        wb(5, 32'hAA);
        step("wr_r5");
        idle();
        in_valid = 1; in_is_ret = 1; in_inst = mk(0, 2, 0);
        step("ret");
        check("ret.op1", out_op1, 32'h80);
        idle();
        in_valid = 1; in_is_st = 1; in_inst = mki(5, 0, 1, 16'h8001);
        step("st");
        check("st.sdata", out_sdata, 32'hAA);
        check("st.op2", out_op2, 32'h0000_8001);

        idle();
        in_valid = 1; in_inst = mki(2, 1, 0, 16'h8001);
        step("imm00");
        check("imm00.op2", out_op2, 32'hFFFF_8001);
        in_inst = mki(2, 1, 1, 16'h8001);
        step("imm01");
        check("imm01.op2", out_op2, 32'h0000_8001);
        in_inst = mki(2, 1, 2, 16'h8001);
        step("imm10");
        check("imm10.op2", out_op2, 32'h8001_0000);
        in_inst = mki(2, 1, 3, 16'h8001);
        step("imm11");
        check("imm11.op2", out_op2, 32'hFFFF_8001);

        // Backpressure: output register holds while stalled.
        in_inst = mk(6, 3, 5);
        out_ready = 0;
        step("stall_load");
        snap_op1 = out_op1;
        for (int i = 0; i < 3; i++) begin
            in_inst = mk(7, 5, 15);
            wb(3, 32'hDEAD_0000 + 32'(i));
            step("stall");
            check("stall.in_ready", {31'b0, in_ready}, 32'd0);
            check("stall.op1_frozen", out_op1, snap_op1);
        end
        wb_en = 0;
        out_ready = 1;
        step("release");
        check("release.inst", out_inst, mk(7, 5, 15));
        check("release.op1", out_op1, 32'hAA);

        idle();
        wb(4, 32'd5);
        step("wr_r4_old");
        in_valid = 1; in_inst = mk(0, 4, 0);
        wb(4, 32'd7);
        step("bypass");
`ifdef OF_WB_BYPASS_EN
        check("bypass.op1", out_op1, 32'd7);
`else
        check("bypass.op1", out_op1, 32'd5);
`endif

        idle();
        in_valid = 1; in_inst = mk(1, 1, 1);
        out_ready = 0;
        step("pre_flush");
        in_flush = 1; in_inst = mk(9, 2, 2);
        wb(9, 32'h99);
        step("flush");
        check("flush.valid", {31'b0, out_valid}, 32'd0);
        idle();
        in_inst = mk(0, 9, 0); in_valid = 1;
        step("after_flush");
        check("after_flush.op1", out_op1, 32'h99);

        out_ready = 0;
        step("stall2");
        rst = 1;
        step("rst_mid");
        check("rst_mid.valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid.op1", out_op1, 32'd0);
        rst = 0; in_valid = 0; out_ready = 1;
        check("rst_mid.ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1; in_inst = mk(0, 9, 3);
        step("post_rst");
        check("post_rst.op1", out_op1, 32'd0);

        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = 1'($urandom);
            in_inst   = $urandom;
            in_is_ret = ($urandom_range(0, 7) == 0);
            in_is_st  = ($urandom_range(0, 3) == 0);
            in_flush  = ($urandom_range(0, 15) == 0);
            wb_en     = 1'($urandom);
            wb_addr   = 4'($urandom);
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001: Parameter XLEN, default 32, register and operand width; SHALL be >= 16.
REQ-002: Parameter NUM_REGS, default 16, number of architectural registers; SHALL be a power of two, 2..16.
REQ-003: Parameter RA_REG, default 15, index read as op1 for ret; SHALL be < NUM_REGS.
REQ-004: clk  in  1  single clock; all state updates on rising edge.
REQ-005: rst  in  1  reset, synchronous, active-high.
REQ-006: in_valid  in  1  instruction offered; in_ready  out  1  stage can accept.
REQ-007: in_inst  in  32  instruction word; fields rd=[25:22], rs1=[21:18], rs2=[17:14], I=[26], modifier=[17:16], imm=[15:0].
REQ-008: in_is_ret, in_is_st  in  1 each  decode flags, qualified by in_valid.
REQ-009: in_flush  in  1  discard the output-register contents and any same-cycle transfer.
REQ-010: wb_en  in  1; wb_addr  in  4; wb_data  in  XLEN  register write port.
REQ-011: out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-012: out_op1, out_op2, out_sdata  out  XLEN each; out_rd  out  4; out_inst  out  32.

Function
REQ-013: Register file SHALL hold NUM_REGS x XLEN, one write port, three combinational read ports (A, B, C).
REQ-014: Port A index SHALL be RA_REG when in_is_ret, else rs1; port B index rs2; port C index rd.
REQ-015: Index bits above log2(NUM_REGS) SHALL be ignored on reads and writes.
REQ-016: With I=0, op2 SHALL be port B data; with I=1, op2 SHALL be immx: modifier 00 sign-extend imm, 01 zero-extend imm, 10 imm shifted left 16 with low 16 bits zero, 11 treated as 00.
REQ-017: immx SHALL be sized to XLEN; for XLEN=16, the modifier-10 result is 0.
REQ-018: sdata SHALL be port C data when in_is_st, else 0.
REQ-019: in_ready SHALL equal (!out_valid || out_ready), combinational, independent of in_valid and in_flush.
REQ-020: A transfer occurs when in_valid && in_ready && !in_flush; the output register then loads op1, op2, sdata, rd, inst and sets out_valid=1 next cycle; latency exactly one cycle.
REQ-021: When out_valid && !out_ready, all outputs SHALL hold stable.
REQ-022: When out_valid && out_ready with no new transfer, out_valid SHALL clear next cycle.
REQ-023: in_flush=1 SHALL clear out_valid next cycle and block any transfer that cycle; register writes still occur.
REQ-024: wb_en=1 SHALL write wb_data to wb_addr at the clock edge, regardless of handshake or flush state.
REQ-025: Values already in the output register SHALL NOT be altered by later writes.

Reset
REQ-026: rst=1 SHALL, at the next edge, clear all registers to 0 and set out_valid, out_op1, out_op2, out_sdata, out_rd and out_inst to 0.
REQ-027: rst SHALL take priority over wb_en, transfers and flush; an in-flight output is dropped.
REQ-028: in_ready SHALL read 1 in the cycle after reset.

Configuration
REQ-029: Macro OF_WB_BYPASS_EN defined: a read port whose masked index equals masked wb_addr while wb_en=1 SHALL return wb_data in the same cycle.
REQ-030: Without OF_WB_BYPASS_EN: reads SHALL return the pre-write register value; the hazard is left to the issue logic.

Verification
REQ-031: Reset, write r3=0x1234 (wb), then add inst rs1=3, rs2=3, I=0 -> one cycle later out_valid=1, op1=op2=0x00001234.
REQ-032: ret inst with r15=0x80, rs1 field=2 -> op1=0x80; st inst with rd=5, r5=0xAA -> sdata=0xAA, op2=immx.
REQ-033: imm=0x8001 with modifiers 00/01/10 -> op2 = 0xFFFF8001 / 0x00008001 / 0x80010000.
REQ-034: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; release -> next instruction follows in the next cycle.
REQ-035: wb_en writes r4=7 in the same cycle r4 is read -> op1=7 with OF_WB_BYPASS_EN, previous r4 without it.
REQ-036: Flush asserted with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, instruction dropped; rst mid-stall -> all outputs 0.
